// File: rtl/spi_boot_loader_if.sv
// rtl/spi_boot_loader_if.sv - SPI flash pins and RAM write port of the boot loader
interface spi_boot_loader_if;
   logic        spi_sck;
   logic        spi_cs;
   logic        spi_mosi;
   logic        spi_miso;
   logic [14:0] ram_addr;
   logic [7:0]  ram_din;
   logic        ram_we;

   modport master (
      output spi_sck, spi_cs, spi_mosi, ram_addr, ram_din, ram_we,
      input  spi_miso
   );

   modport slave (
      input  spi_sck, spi_cs, spi_mosi, ram_addr, ram_din, ram_we,
      output spi_miso
   );
endinterface

// File: rtl/spi_boot_loader.sv
// rtl/spi_boot_loader.sv - copies a boot image from SPI flash (READ 0x03) into RAM, then releases the CPU
// Optional trailer checksum byte enabled by defining SPI_BOOT_CHECKSUM_EN.
module spi_boot_loader #(
   parameter logic [23:0] FLASH_BASE = 24'h010000,
   parameter logic [14:0] RAM_BASE   = 15'h0000,
   parameter int          LOAD_BYTES = 1024,
   parameter int          CLK_DIV    = 2
) (
   input  logic              clk,
   input  logic              reset,
   spi_boot_loader_if.master bus,
   output logic              cpu_reset,
   output logic              boot_done,
   output logic              boot_error
);

`ifdef SPI_BOOT_CHECKSUM_EN
   localparam int TOTAL_BYTES = LOAD_BYTES + 1;
`else
   localparam int TOTAL_BYTES = LOAD_BYTES;
`endif
   localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [15:0]     IMG_BYTES = 16'(LOAD_BYTES);
   localparam logic [15:0]     LAST_BYTE = 16'(TOTAL_BYTES - 1);
   localparam logic [31:0]     CMD_ADDR  = {8'h03, FLASH_BASE};

   typedef enum logic [2:0] {
      S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DATA, S_CS_HOLD, S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              half_q, half_d;
   logic [4:0]        bit_cnt_q, bit_cnt_d;
   logic [15:0]       byte_cnt_q, byte_cnt_d;
   logic [30:0]       tx_q, tx_d;
   logic [6:0]        rx_q, rx_d;
   logic              sck_q, sck_d;
   logic              cs_q, cs_d;
   logic              mosi_q, mosi_d;
   logic [14:0]       addr_q, addr_d;
   logic [7:0]        din_q, din_d;
   logic              we_q, we_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;
   logic              tick;
   logic [7:0]        rx_next;
`ifdef SPI_BOOT_CHECKSUM_EN
   logic [7:0]        sum_q, sum_d;
   logic              error_q, error_d;
`endif

   // Next-state and output logic; tick marks the last clk of each SCK half-period
   always_comb begin
      tick        = (div_q == DIV_LAST);
      rx_next     = {rx_q, bus.spi_miso};
      state_d     = state_q;
      div_d       = tick ? '0 : div_q + DIV_W'(1);
      half_d      = half_q;
      bit_cnt_d   = bit_cnt_q;
      byte_cnt_d  = byte_cnt_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      sck_d       = sck_q;
      cs_d        = cs_q;
      mosi_d      = mosi_q;
      addr_d      = addr_q;
      din_d       = din_q;
      we_d        = 1'b0;
      cpu_reset_d = cpu_reset_q;
      done_d      = done_q;
`ifdef SPI_BOOT_CHECKSUM_EN
      sum_d       = sum_q;
      error_d     = error_q;
`endif
      case (state_q)
         S_IDLE: begin
            div_d   = '0;
            cs_d    = 1'b0;
            state_d = S_CS_SETUP;
         end
         S_CS_SETUP: begin
            if (tick) begin
               state_d   = S_CMD;
               half_d    = 1'b0;
               bit_cnt_d = '0;
               mosi_d    = CMD_ADDR[31];
               tx_d      = CMD_ADDR[30:0];
            end
         end
         S_CMD, S_ADDR, S_DATA: begin
            if (tick) begin
               if (!half_q) begin
                  // SCK rises: MISO is captured in this same cycle
                  half_d = 1'b1;
                  sck_d  = 1'b1;
                  if (state_q == S_DATA) begin
                     rx_d = rx_next[6:0];
                     if (bit_cnt_q == 5'd7) begin
`ifdef SPI_BOOT_CHECKSUM_EN
                        sum_d = sum_q + rx_next;
`endif
                        if (byte_cnt_q < IMG_BYTES) begin
                           we_d   = 1'b1;
                           addr_d = RAM_BASE + byte_cnt_q[14:0];
                           din_d  = rx_next;
                        end
                     end
                  end
               end else begin
                  // SCK falls: next bit starts; tx drains to zeros so MOSI is 0 in DATA
                  half_d    = 1'b0;
                  sck_d     = 1'b0;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  mosi_d    = tx_q[30];
                  tx_d      = {tx_q[29:0], 1'b0};
                  case (state_q)
                     S_CMD: begin
                        if (bit_cnt_q == 5'd7) begin
                           state_d   = S_ADDR;
                           bit_cnt_d = '0;
                        end
                     end
                     S_ADDR: begin
                        if (bit_cnt_q == 5'd23) begin
                           state_d    = S_DATA;
                           bit_cnt_d  = '0;
                           byte_cnt_d = '0;
                        end
                     end
                     default: begin
                        if (bit_cnt_q == 5'd7) begin
                           bit_cnt_d = '0;
                           if (byte_cnt_q == LAST_BYTE) begin
                              state_d = S_CS_HOLD;
                           end else begin
                              byte_cnt_d = byte_cnt_q + 16'd1;
                           end
                        end
                     end
                  endcase
               end
            end
         end
         S_CS_HOLD: begin
            // First half: CS low with SCK idle; second half: CS high before handover
            if (tick) begin
               if (!half_q) begin
                  cs_d   = 1'b1;
                  half_d = 1'b1;
               end else begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
`ifdef SPI_BOOT_CHECKSUM_EN
                  error_d     = (sum_q != 8'h00);
                  cpu_reset_d = (sum_q != 8'h00);
`else
                  cpu_reset_d = 1'b0;
`endif
               end
            end
         end
         S_DONE: begin
            div_d = '0;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State register with synchronous abort to IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         half_q      <= 1'b0;
         bit_cnt_q   <= '0;
         byte_cnt_q  <= '0;
         tx_q        <= '0;
         rx_q        <= '0;
         sck_q       <= 1'b0;
         cs_q        <= 1'b1;
         mosi_q      <= 1'b0;
         addr_q      <= '0;
         din_q       <= '0;
         we_q        <= 1'b0;
         cpu_reset_q <= 1'b1;
         done_q      <= 1'b0;
`ifdef SPI_BOOT_CHECKSUM_EN
         sum_q       <= '0;
         error_q     <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         half_q      <= half_d;
         bit_cnt_q   <= bit_cnt_d;
         byte_cnt_q  <= byte_cnt_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         sck_q       <= sck_d;
         cs_q        <= cs_d;
         mosi_q      <= mosi_d;
         addr_q      <= addr_d;
         din_q       <= din_d;
         we_q        <= we_d;
         cpu_reset_q <= cpu_reset_d;
         done_q      <= done_d;
`ifdef SPI_BOOT_CHECKSUM_EN
         sum_q       <= sum_d;
         error_q     <= error_d;
`endif
      end
   end

   assign bus.spi_sck  = sck_q;
   assign bus.spi_cs   = cs_q;
   assign bus.spi_mosi = mosi_q;
   assign bus.ram_addr = addr_q;
   assign bus.ram_din  = din_q;
   assign bus.ram_we   = we_q;
   assign cpu_reset    = cpu_reset_q;
   assign boot_done    = done_q;
`ifdef SPI_BOOT_CHECKSUM_EN
   assign boot_error   = error_q;
`else
   assign boot_error   = 1'b0;
`endif

endmodule

// File: tb/tb_spi_boot_loader.sv
// tb/tb_spi_boot_loader.sv - bench for spi_boot_loader over several parameter sets with a flash/RAM model
module tb_spi_boot_loader;
   localparam int N_INST = 7;
   localparam int CDIV [N_INST] = '{2, 1, 3, 2, 2, 2, 2};
   localparam int NBYT [N_INST] = '{4, 4, 4, 1, 8, 4, 4};
   localparam logic [14:0] RBASE [N_INST] = '{15'h0000, 15'h0100, 15'h7FFE, 15'h1234,
                                              15'h0000, 15'h0040, 15'h0040};
   localparam logic [23:0] FBASE [N_INST] = '{24'h010000, 24'h123456, 24'h010000, 24'h010000,
                                              24'hABCDEF, 24'h010000, 24'h010000};
`ifdef SPI_BOOT_CHECKSUM_EN
   localparam int   EXTRA = 8;
   localparam logic BAD   = 1'b1;
`else
   localparam int   EXTRA = 0;
   localparam logic BAD   = 1'b0;
`endif

   typedef struct {
      int          inst;
      int          exp_rises;
      int          exp_we;
      logic        exp_err;
      logic        exp_cpu_rst;
      logic [31:0] exp_cmd;
   } vec_t;

   logic clk = 1'b0;
   logic [N_INST-1:0] rst;
   logic [N_INST-1:0] cs_w, sck_w, mosi_w, we_w, done_w, cpurst_w, err_w;
   logic [N_INST-1:0] miso_r;
   logic [14:0] addr_w [N_INST];
   logic [7:0]  din_w [N_INST];

   logic [7:0]  img [N_INST][8];
   logic [7:0]  trl [N_INST];
   logic [7:0]  ram_m [0:N_INST*32768-1];
   int          since [N_INST];
   int          rises [N_INST];
   int          we_cnt [N_INST];
   int          done_rises [N_INST];
   int          edge_err [N_INST];
   int          sync_err [N_INST];
   logic [31:0] cmd [N_INST];
   logic        prev_cs [N_INST];
   logic        prev_sck [N_INST];
   logic        prev_we [N_INST];
   logic        prev_done [N_INST];
   logic        first [N_INST];

   int errors;
   int checks;
   vec_t vecs [N_INST];

   always #5 clk = ~clk;

   for (genvar g = 0; g < N_INST; g++) begin : gen_dut
      spi_boot_loader_if bus ();
      spi_boot_loader #(
         .FLASH_BASE (FBASE[g]),
         .RAM_BASE   (RBASE[g]),
         .LOAD_BYTES (NBYT[g]),
         .CLK_DIV    (CDIV[g])
      ) dut (
         .clk        (clk),
         .reset      (rst[g]),
         .bus        (bus),
         .cpu_reset  (cpurst_w[g]),
         .boot_done  (done_w[g]),
         .boot_error (err_w[g])
      );
      assign bus.spi_miso = miso_r[g];
      assign cs_w[g]      = bus.spi_cs;
      assign sck_w[g]     = bus.spi_sck;
      assign mosi_w[g]    = bus.spi_mosi;
      assign we_w[g]      = bus.ram_we;
      assign addr_w[g]    = bus.ram_addr;
      assign din_w[g]     = bus.ram_din;
   end

   // Byte stream the flash returns after the 32 command/address bits: image, then trailer
   function automatic logic flash_bit(input int i, input int k);
      int b;
      logic [7:0] v;
      b = k / 8;
      if (b < NBYT[i]) v = img[i][b];
      else if (b == NBYT[i]) v = trl[i];
      else v = 8'h00;
      return v[7 - (k % 8)];
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Flash model, RAM model and SPI timing monitor, sampled mid-cycle
   always @(negedge clk) begin
      for (int i = 0; i < N_INST; i++) begin
         if (rst[i]) begin
            prev_cs[i] = 1'b1; prev_sck[i] = 1'b0; prev_we[i] = 1'b0; prev_done[i] = 1'b0;
            since[i] = 0; first[i] = 1'b0; we_cnt[i] = 0; miso_r[i] = 1'b0;
         end else begin
            since[i]++;
            if (prev_cs[i] && !cs_w[i]) begin
               since[i] = 0; first[i] = 1'b1; rises[i] = 0; cmd[i] = '0;
            end else if (!prev_cs[i] && cs_w[i]) begin
               if (since[i] < CDIV[i] || sck_w[i]) edge_err[i]++;
            end else if (sck_w[i] != prev_sck[i]) begin
               if (cs_w[i]) edge_err[i]++;
               else if (first[i]) begin
                  if (since[i] != 2 * CDIV[i]) edge_err[i]++;
                  first[i] = 1'b0;
               end else if (since[i] != CDIV[i]) edge_err[i]++;
               since[i] = 0;
               if (sck_w[i]) begin
                  rises[i]++;
                  if (rises[i] <= 32) cmd[i] = {cmd[i][30:0], mosi_w[i]};
                  else if (mosi_w[i]) edge_err[i]++;
               end else if (rises[i] >= 32) begin
                  miso_r[i] = flash_bit(i, rises[i] - 32);
               end
            end
            if (we_w[i]) begin
               if (prev_we[i]) edge_err[i]++;
               ram_m[i*32768 + int'(addr_w[i])] = din_w[i];
               we_cnt[i]++;
            end
            if (done_w[i] && !prev_done[i]) done_rises[i]++;
            if (cpurst_w[i] != !(done_w[i] && !err_w[i])) sync_err[i]++;
            prev_cs[i] = cs_w[i]; prev_sck[i] = sck_w[i];
            prev_we[i] = we_w[i]; prev_done[i] = done_w[i];
         end
      end
   end

   initial begin
      logic [7:0] s;
      int c;
      errors = 0;
      checks = 0;
      rst = '1;
      miso_r = '0;
      for (int i = 0; i < N_INST; i++) begin
         edge_err[i] = 0; sync_err[i] = 0; done_rises[i] = 0; rises[i] = 0;
         we_cnt[i] = 0; cmd[i] = '0;
         for (int n = 0; n < 8; n++) img[i][n] = 8'($urandom);
      end
      img[0][0] = 8'h11; img[0][1] = 8'h22; img[0][2] = 8'h33; img[0][3] = 8'h44;
      img[3][0] = 8'hA5;
      for (int i = 5; i < 7; i++) begin
         img[i][0] = 8'h01; img[i][1] = 8'h02; img[i][2] = 8'h03; img[i][3] = 8'h04;
      end
      for (int i = 0; i < N_INST; i++) begin
         s = 8'h00;
         for (int n = 0; n < NBYT[i]; n++) s = s + img[i][n];
         trl[i] = 8'h00 - s;
      end
      trl[5] = 8'hF6;
      trl[6] = 8'hF7;

      vecs[0] = '{0, 64 + EXTRA, 4, 1'b0, 1'b0, 32'h03010000};
      vecs[1] = '{1, 64 + EXTRA, 4, 1'b0, 1'b0, 32'h03123456};
      vecs[2] = '{2, 64 + EXTRA, 4, 1'b0, 1'b0, 32'h03010000};
      vecs[3] = '{3, 40 + EXTRA, 1, 1'b0, 1'b0, 32'h03010000};
      vecs[4] = '{4, 96 + EXTRA, 8, 1'b0, 1'b0, 32'h03ABCDEF};
      vecs[5] = '{5, 64 + EXTRA, 4, 1'b0, 1'b0, 32'h03010000};
      vecs[6] = '{6, 64 + EXTRA, 4, BAD, BAD, 32'h03010000};

      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < N_INST; i++)
         chk($sformatf("reset_state_%0d", i),
             32'({cs_w[i], sck_w[i], mosi_w[i], addr_w[i], din_w[i], we_w[i],
                  cpurst_w[i], done_w[i], err_w[i]}),
             32'({1'b1, 1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}));

      @(posedge clk);
      #1 rst = '0;

      // Abort instance 4 in the middle of its second data byte
      c = 0;
      while (c < 3000 && we_cnt[4] < 1) begin
         @(posedge clk);
         c++;
      end
      chk("abort_first_write_seen", 32'(we_cnt[4] >= 1), 32'd1);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_cs_low_before", 32'(cs_w[4]), 32'd0);
      rst[4] = 1'b1;
      @(posedge clk);
      #1 rst[4] = 1'b0;
      chk("abort_cs_high_next_cycle", 32'(cs_w[4]), 32'd1);

      c = 0;
      while (c < 20000 && done_w != '1) begin
         @(posedge clk);
         c++;
      end
      chk("all_done_in_budget", 32'(done_w), 32'((1 << N_INST) - 1));
      repeat (10) @(posedge clk);
      @(negedge clk);

      for (int v = 0; v < N_INST; v++) begin
         int i;
         i = vecs[v].inst;
         chk($sformatf("boot_done_%0d", i), 32'(done_w[i]), 32'd1);
         chk($sformatf("cpu_reset_%0d", i), 32'(cpurst_w[i]), 32'(vecs[v].exp_cpu_rst));
         chk($sformatf("boot_error_%0d", i), 32'(err_w[i]), 32'(vecs[v].exp_err));
         chk($sformatf("sck_rises_%0d", i), 32'(rises[i]), 32'(vecs[v].exp_rises));
         chk($sformatf("ram_we_pulses_%0d", i), 32'(we_cnt[i]), 32'(vecs[v].exp_we));
         chk($sformatf("cmd_addr_%0d", i), cmd[i], vecs[v].exp_cmd);
         chk($sformatf("timing_errs_%0d", i), 32'(edge_err[i]), 32'd0);
         chk($sformatf("cpu_reset_sync_errs_%0d", i), 32'(sync_err[i]), 32'd0);
         chk($sformatf("done_rises_%0d", i), 32'(done_rises[i]), 32'd1);
         for (int n = 0; n < NBYT[i]; n++) begin
            int a;
            a = (int'(RBASE[i]) + n) % 32768;
            chk($sformatf("ram_%0d_addr_%0h", i, a), 32'(ram_m[i*32768 + a]), 32'(img[i][n]));
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
